// File: rtl/optical_link_pkg.sv
// optical_link_pkg: shared optical link types and constants (transmit states, bit-rate default, sync byte, header layout)
package optical_link_pkg;
  typedef enum logic [2:0] {IDLE, PRE, HDR, PAY, CHK, GAP} tx_state_t;
  localparam int BIT_CYCLES_125K = 216;
  localparam logic [7:0] PREAMBLE_BYTE = 8'hD5;
  localparam int HDR_GRANT_BIT = 7;
endpackage

// File: rtl/bit_tick_gen.sv
// bit_tick_gen: bit-period timebase, one-cycle tick every CYCLES clocks
// Ports: clock, reset (sync, active-high), clear (sync restart at count 0), tick (high on the last clock of each period)
module bit_tick_gen #(
  parameter int CYCLES = 216
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);
  localparam int CW = $clog2(CYCLES);
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);
  logic [CW-1:0] cnt;
  assign tick = (cnt == LAST);
  always_ff @(posedge clock) begin
    if (reset || clear) cnt <= '0;
    else cnt <= tick ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/optical_tx_scheduler.sv
// optical_tx_scheduler: round-robin frame scheduler and MSB-first LED serializer for two byte-stream requesters
// Ports: clock, reset (sync, active-high); req_valid[1:0], req_data0, req_data1, req_last[1:0] from the requesters;
//        req_ready[1:0] consume pulses; tx_bit LED drive; bit_strobe first clock of each bit; busy frame+gap active;
//        grant frame owner; underrun truncated-frame pulse.
// Build option: define OPTICAL_TX_CHECKSUM_EN to append the XOR checksum byte to every frame.
module optical_tx_scheduler
  import optical_link_pkg::*;
#(
  parameter int         BIT_CYCLES = BIT_CYCLES_125K,
  parameter logic [7:0] PREAMBLE   = PREAMBLE_BYTE,
  parameter int         MAX_LEN    = 64,
  parameter int         GAP_BITS   = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req_valid,
  input  logic [7:0] req_data0,
  input  logic [7:0] req_data1,
  input  logic [1:0] req_last,
  output logic [1:0] req_ready,
  output logic       tx_bit,
  output logic       bit_strobe,
  output logic       busy,
  output logic       grant,
  output logic       underrun
);
  localparam logic [7:0]  LEN_END = 8'(MAX_LEN - 1);
  localparam logic [15:0] GAP_END = 16'(GAP_BITS - 1);
`ifdef OPTICAL_TX_CHECKSUM_EN
  localparam tx_state_t TAIL = CHK;
`else
  localparam tx_state_t TAIL = GAP;
`endif
  tx_state_t state, state_n;
  logic tick, byte_end, slot, take, pick, rr, done;
  logic [2:0] bidx;
  logic [7:0] sh, nbytes, data, hdr, nb;
  logic [15:0] gcnt;
`ifdef OPTICAL_TX_CHECKSUM_EN
  logic [7:0] cks;
`endif
  // tx_bit comes straight from the shift register MSB; zeros shift in, so the line idles low
  assign tx_bit = sh[7];
  assign busy = (state != IDLE);
  // Holding the counter clear in IDLE makes the first preamble bit a full period
  bit_tick_gen #(.CYCLES(BIT_CYCLES)) u_tick (
    .clock(clock),
    .reset(reset),
    .clear(state == IDLE),
    .tick(tick)
  );
  always_comb begin
    byte_end = tick && bidx == 3'd7;
    // A payload slot is any byte boundary that could load a payload byte
    slot = byte_end && (state == HDR || (state == PAY && !done));
    take = slot && req_valid[grant];
    pick = &req_valid ? rr : req_valid[1];
    data = grant ? req_data1 : req_data0;
    hdr = 8'h00;
    hdr[HDR_GRANT_BIT] = grant;
    state_n = state;
    case (state)
      IDLE:     state_n = |req_valid ? PRE : IDLE;
      PRE:      state_n = byte_end ? HDR : PRE;
      HDR, PAY: state_n = byte_end ? (take ? PAY : TAIL) : state;
      CHK:      state_n = byte_end ? GAP : CHK;
      GAP:      state_n = tick && gcnt == GAP_END ? IDLE : GAP;
      default:  state_n = IDLE;
    endcase
`ifdef OPTICAL_TX_CHECKSUM_EN
    nb = state_n == HDR ? hdr : state_n == PAY ? data : state_n == CHK ? cks : 8'h00;
`else
    nb = state_n == HDR ? hdr : state_n == PAY ? data : 8'h00;
`endif
    req_ready = take && !reset ? (grant ? 2'b10 : 2'b01) : 2'b00;
    underrun = slot && !req_valid[grant] && !reset;
  end
  always_ff @(posedge clock) state <= reset ? IDLE : state_n;
  always_ff @(posedge clock) begin
    if (reset) begin
      sh <= '0;
      bit_strobe <= 1'b0;
      grant <= 1'b0;
      rr <= 1'b0;
      bidx <= '0;
      nbytes <= '0;
      done <= 1'b0;
      gcnt <= '0;
`ifdef OPTICAL_TX_CHECKSUM_EN
      cks <= '0;
`endif
    end else if (state == IDLE) begin
      bit_strobe <= |req_valid;
      if (|req_valid) begin
        grant <= pick;
        rr <= !pick;
        sh <= PREAMBLE;
        bidx <= '0;
        nbytes <= '0;
        done <= 1'b0;
        gcnt <= '0;
`ifdef OPTICAL_TX_CHECKSUM_EN
        cks <= '0;
`endif
      end
    end else if (tick) begin
      bit_strobe <= state_n != IDLE;
      if (state == GAP) gcnt <= gcnt + 1'b1;
      else begin
        bidx <= bidx + 1'b1;
        sh <= byte_end ? nb : {sh[6:0], 1'b0};
      end
      if (take) begin
        nbytes <= nbytes + 1'b1;
        done <= req_last[grant] || nbytes == LEN_END;
`ifdef OPTICAL_TX_CHECKSUM_EN
        cks <= cks ^ data;
`endif
      end
    end else bit_strobe <= 1'b0;
  end
endmodule

// File: tb/tb_optical_tx_scheduler.sv
// tb_optical_tx_scheduler: directed and randomized frame checks against a byte-level frame model
module tb_optical_tx_scheduler;
  typedef logic [7:0] u8;
  localparam int BC = 6;
  localparam int ML = 64;
  localparam int GB = 16;
`ifdef OPTICAL_TX_CHECKSUM_EN
  localparam int C = 1;
`else
  localparam int C = 0;
`endif
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [1:0] req_valid = 2'b00;
  logic [7:0] req_data0 = 8'h00;
  logic [7:0] req_data1 = 8'h00;
  logic [1:0] req_last = 2'b00;
  logic [1:0] req_ready;
  logic tx_bit, bit_strobe, busy, grant, underrun;

  optical_tx_scheduler #(.BIT_CYCLES(BC), .PREAMBLE(8'hD5), .MAX_LEN(ML), .GAP_BITS(GB)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_data0(req_data0), .req_data1(req_data1),
    .req_last(req_last), .req_ready(req_ready), .tx_bit(tx_bit), .bit_strobe(bit_strobe), .busy(busy),
    .grant(grant), .underrun(underrun)
  );

  always #5 clock = ~clock;

  int n_assert = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // requester behaviour: present queued bytes, pop one after each acknowledged handshake
  u8 qd0[$], qd1[$];
  bit ql0[$], ql1[$];
  logic [1:0] en = 2'b11;
  int rdy0 = 0, rdy1 = 0, urun = 0, rise_cyc = 0;
  int r0c[$];
  initial begin
    bit pend0, pend1, was_any;
    pend0 = 0; pend1 = 0; was_any = 0;
    forever begin
      @(negedge clock);
      if (pend0 && qd0.size() > 0) begin void'(qd0.pop_front()); void'(ql0.pop_front()); end
      if (pend1 && qd1.size() > 0) begin void'(qd1.pop_front()); void'(ql1.pop_front()); end
      req_valid[0] = en[0] && qd0.size() > 0;
      req_valid[1] = en[1] && qd1.size() > 0;
      req_data0 = qd0.size() > 0 ? qd0[0] : 8'h00;
      req_data1 = qd1.size() > 0 ? qd1[0] : 8'h00;
      req_last[0] = ql0.size() > 0 ? ql0[0] : 1'b0;
      req_last[1] = ql1.size() > 0 ? ql1[0] : 1'b0;
      if (!was_any && |req_valid) rise_cyc = cyc;
      was_any = |req_valid;
      #1;
      pend0 = req_ready[0] === 1'b1;
      pend1 = req_ready[1] === 1'b1;
      if (pend0) begin rdy0++; r0c.push_back(cyc); end
      if (pend1) rdy1++;
      if (underrun === 1'b1) urun++;
    end
  end

  // line monitor: rebuild frames from tx_bit sampled mid-bit while busy is high
  u8 mb[$];
  int f_start[$], f_cyc[$], f_nb[$], f_gap[$], f_err[$], f_gr[$];
  initial begin
    bit inf, cur, gr, gapok;
    int st, pos, errs, nbits, nb;
    bit bq[$], fs[$];
    logic [7:0] v;
    inf = 0; cur = 0; gr = 0; st = 0; pos = 0; errs = 0;
    forever begin
      @(posedge clock); #1;
      if (busy === 1'b1) begin
        if (!inf) begin inf = 1; st = cyc; pos = 0; errs = 0; bq.delete(); fs.delete(); gr = grant; end
        if (pos == 0) begin cur = tx_bit; fs.push_back(bit_strobe); end
        else begin
          if (bit_strobe !== 1'b0) errs++;
          if (tx_bit !== cur) errs++;
        end
        if (pos == BC / 2) bq.push_back(tx_bit);
        pos = (pos == BC - 1) ? 0 : pos + 1;
      end else if (inf) begin
        inf = 0;
        nbits = bq.size();
        nb = nbits >= GB ? (nbits - GB) / 8 : 0;
        gapok = 1;
        for (int b = 0; b < nbits; b++) begin
          if (b < 8 * nb && !fs[b]) errs++;
          if (b >= 8 * nb && bq[b]) gapok = 0;
        end
        for (int k = 0; k < nb; k++) begin
          v = 8'h00;
          for (int j = 0; j < 8; j++) v = {v[6:0], bq[8 * k + j]};
          mb.push_back(v);
        end
        f_start.push_back(st); f_cyc.push_back(cyc - st); f_nb.push_back(nb);
        f_gap.push_back(int'(gapok)); f_err.push_back(errs); f_gr.push_back(int'(gr));
      end
    end
  end

  // arbitration model: tie goes to the requester not granted last, requester 0 after reset
  int last_g = -1;
  function automatic int arb(bit v0, bit v1);
    int w;
    w = (v0 && v1) ? (last_g == 0 ? 1 : 0) : (v1 ? 1 : 0);
    last_g = w;
    return w;
  endfunction

  task automatic check_frame(input string tag, input int g, input u8 p[$], output int st);
    u8 e[$];
    u8 got[$];
    u8 x;
    int nb;
    x = 8'h00;
    st = -1;
    e.push_back(8'hD5);
    e.push_back(g != 0 ? 8'h80 : 8'h00);
    foreach (p[i]) begin e.push_back(p[i]); x ^= p[i]; end
    if (C == 1) e.push_back(x);
    for (int i = 0; i < 20000 && f_start.size() == 0; i++) @(posedge clock);
    chk({tag, "_seen"}, f_start.size() != 0, 1);
    if (f_start.size() == 0) return;
    st = f_start.pop_front();
    nb = f_nb.pop_front();
    for (int i = 0; i < nb; i++) got.push_back(mb.pop_front());
    chk({tag, "_nbytes"}, nb, e.size());
    chk({tag, "_busy_cycles"}, f_cyc.pop_front(), (8 * e.size() + GB) * BC);
    chk({tag, "_gap_low"}, f_gap.pop_front(), 1);
    chk({tag, "_strobe_hold"}, f_err.pop_front(), 0);
    chk({tag, "_grant"}, f_gr.pop_front(), g);
    for (int i = 0; i < e.size() && i < nb; i++) chk($sformatf("%s_byte%0d", tag, i), got[i], e[i]);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    u8 p[$], pk0[$], pk1[$];
    int st, r0, r1, u0, g, len, sz;
    u8 b;
    // reset values
    repeat (3) @(posedge clock);
    #1;
    chk("rst_tx_bit", tx_bit, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_strobe", bit_strobe, 0);
    chk("rst_underrun", underrun, 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (4) @(posedge clock);

    // both requesters continuously valid with 1-byte packets: grants alternate
    r0 = rdy0; r1 = rdy1;
    for (int i = 0; i < 2; i++) begin
      b = 8'($urandom); qd0.push_back(b); ql0.push_back(1'b1); pk0.push_back(b);
      b = 8'($urandom); qd1.push_back(b); ql1.push_back(1'b1); pk1.push_back(b);
    end
    for (int i = 0; i < 4; i++) begin
      g = arb(pk0.size() > 0, pk1.size() > 0);
      p.delete();
      if (g == 0) p.push_back(pk0.pop_front()); else p.push_back(pk1.pop_front());
      check_frame($sformatf("rr%0d", i), g, p, st);
    end
    chk("rr_ready0", rdy0 - r0, 2);
    chk("rr_ready1", rdy1 - r1, 2);

    // single packet {12, 34}: bit stream, latency and ready spacing
    repeat (10) @(posedge clock);
    r0 = rdy0; u0 = urun;
    qd0.push_back(8'h12); ql0.push_back(1'b0);
    qd0.push_back(8'h34); ql0.push_back(1'b1);
    p.delete(); p.push_back(8'h12); p.push_back(8'h34);
    check_frame("pkt", arb(1, 0), p, st);
    chk("pkt_latency", st, rise_cyc + 1);
    chk("pkt_ready_cnt", rdy0 - r0, 2);
    sz = r0c.size();
    chk("pkt_ready_gap", sz >= 2 ? r0c[sz - 1] - r0c[sz - 2] : -1, 8 * BC);
    chk("pkt_no_underrun", urun - u0, 0);

    // requester 1 stops after 2 of 5 bytes: truncated frame
    r0 = rdy0; r1 = rdy1; u0 = urun;
    p.delete();
    for (int i = 0; i < 2; i++) begin
      b = 8'($urandom); qd1.push_back(b); ql1.push_back(1'b0); p.push_back(b);
    end
    check_frame("urun", arb(0, 1), p, st);
    chk("urun_pulses", urun - u0, 1);
    chk("urun_ready1", rdy1 - r1, 2);
    chk("urun_ready0", rdy0 - r0, 0);

    // 70-byte packet split at MAX_LEN
    r0 = rdy0; u0 = urun;
    p.delete();
    for (int i = 0; i < 70; i++) begin
      b = 8'($urandom); qd0.push_back(b); ql0.push_back(i == 69); p.push_back(b);
    end
    pk0 = p[0:ML - 1];
    check_frame("max1", arb(1, 0), pk0, st);
    pk0 = p[ML:69];
    check_frame("max2", arb(1, 0), pk0, st);
    chk("max_no_underrun", urun - u0, 0);
    chk("max_ready", rdy0 - r0, 70);

    // valid withdrawn before the first payload byte: empty frame
    r0 = rdy0; u0 = urun;
    en[0] = 1'b0;
    qd0.push_back(8'hA5); ql0.push_back(1'b1);
    en[0] = 1'b1;
    for (int i = 0; i < 100 && busy !== 1'b1; i++) begin @(posedge clock); #1; end
    en[0] = 1'b0;
    p.delete();
    check_frame("empty", arb(1, 0), p, st);
    chk("empty_underrun", urun - u0, 1);
    chk("empty_ready", rdy0 - r0, 0);
    qd0.delete(); ql0.delete();
    en[0] = 1'b1;

    // randomized single-requester packets
    for (int k = 0; k < 3; k++) begin
      g = int'($urandom_range(0, 1));
      len = int'($urandom_range(1, 5));
      r0 = rdy0; r1 = rdy1;
      p.delete();
      for (int i = 0; i < len; i++) begin
        b = 8'($urandom);
        p.push_back(b);
        if (g == 0) begin qd0.push_back(b); ql0.push_back(i == len - 1); end
        else begin qd1.push_back(b); ql1.push_back(i == len - 1); end
      end
      check_frame($sformatf("rnd%0d", k), arb(g == 0, g == 1), p, st);
      chk($sformatf("rnd%0d_ready", k), g == 0 ? rdy0 - r0 : rdy1 - r1, len);
    end

    // reset in the middle of the payload
    r0 = rdy0;
    for (int i = 0; i < 10; i++) begin qd0.push_back(8'($urandom)); ql0.push_back(i == 9); end
    for (int i = 0; i < 3000 && rdy0 - r0 < 3; i++) @(posedge clock);
    chk("mid_progress", rdy0 - r0, 3);
    @(negedge clock);
    reset = 1'b1;
    r0 = rdy0;
    @(posedge clock); #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_tx_bit", tx_bit, 0);
    chk("mid_rst_strobe", bit_strobe, 0);
    repeat (3) @(posedge clock);
    @(negedge clock); #2;
    chk("mid_rst_no_ready", rdy0 - r0, 0);
    qd0.delete(); ql0.delete(); qd1.delete(); ql1.delete();
    mb.delete(); f_start.delete(); f_cyc.delete(); f_nb.delete(); f_gap.delete(); f_err.delete(); f_gr.delete();
    last_g = -1;
    pk0.delete(); pk1.delete();
    b = 8'($urandom); qd0.push_back(b); ql0.push_back(1'b1); pk0.push_back(b);
    b = 8'($urandom); qd1.push_back(b); ql1.push_back(1'b1); pk1.push_back(b);
    @(negedge clock);
    reset = 1'b0;
    check_frame("post_rst0", arb(1, 1), pk0, st);
    check_frame("post_rst1", arb(0, 1), pk1, st);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/optical_tx_scheduler.md
# optical_tx_scheduler

Transmit-side frame scheduler for the optical link. It arbitrates two byte-stream requesters (req 0 = control, req 1 = data) at frame boundaries, frames the granted stream, and serializes it MSB-first onto the LED drive line. Each bit is held for one bit period of BIT_CYCLES system clocks; the defaults give 27 MHz / 216 = 125 kbit/s. It sits between the packet sources and the LED output pin and owns the bit-rate timebase.

## Interface
- BIT_CYCLES, 216, system clocks per transmitted bit (≥ 2)
- PREAMBLE, 8'hD5, sync byte sent first in every frame
- MAX_LEN, 64, maximum payload bytes per frame (1..255)
- GAP_BITS, 16, idle-low bit periods after every frame (≥ 1)
- clock  in  1  system clock, 27 MHz
- reset  in  1  synchronous, active-high
- req_valid  in  2  per-requester byte valid
- req_data0 / req_data1  in  8 each  payload byte, held stable while the matching valid is high
- req_last  in  2  per-requester: the current byte is the last byte of the packet
- req_ready  out  2  one-cycle pulse: the byte was consumed
- tx_bit  out  1  LED drive line; idle level 0
- bit_strobe  out  1  one-cycle pulse on the first clock of every transmitted bit
- busy  out  1  high from frame start through the end of the gap
- grant  out  1  requester owning the current frame
- underrun  out  1  one-cycle pulse when a frame is truncated

## Operation
- States: IDLE → PRE → HDR → PAY → CHK → GAP → IDLE.
- IDLE:
  - If any req_valid is high, latch grant by round-robin: the requester not granted last wins when both are valid.
  - After reset, requester 0 wins a tie.
  - Clear the bit counter and enter PRE.
- PRE sends PREAMBLE; HDR sends {grant, 7'b0}.
- PAY, byte boundary:
  - If req_valid[grant] is high, load req_data[grant] into the shift register and pulse req_ready[grant] in the same cycle.
  - Accumulate the XOR checksum and increment the byte count.
  - Leave PAY after a byte loaded with req_last=1, or after byte MAX_LEN.
  - If valid is low at a boundary with no last seen, pulse underrun and leave PAY without loading.
  - A frame with zero payload bytes (valid dropped before the first byte) is legal.
- CHK sends the checksum byte (see Configuration).
- GAP holds tx_bit=0 for GAP_BITS periods, then returns to IDLE.
- The non-granted requester is never acknowledged during a frame.
- A byte count reaching MAX_LEN without last ends the frame normally, with no underrun; the remaining bytes go in later frames.

## Timing
- Reset values: tx_bit 0, req_ready 0, bit_strobe 0, busy 0, grant 0, underrun 0, round-robin pointer → requester 0, checksum 0.
- Bit counter runs 0..BIT_CYCLES-1. A bit boundary occurs when the counter wraps.
- Exactly BIT_CYCLES clocks per bit, with no jitter between bytes or across state changes.
- Startup latency: req_valid seen high in IDLE at cycle t → busy and the first PREAMBLE bit on tx_bit at cycle t+1, with bit_strobe at t+1.
- A byte is loaded at the boundary starting its bit 7. req_ready pulses in that same cycle; the requester may change data on the next clock.
- tx_bit and bit_strobe are registered and change only at bit boundaries.
- Frame length in bits: 8×(2 + n + c) + GAP_BITS, where n = payload bytes and c = 1 if the checksum is enabled.
- A reset mid-frame aborts immediately to IDLE with reset values. No req_ready is issued for the partial byte.
- req_valid changes in the middle of a bit are ignored; valid is sampled only at byte boundaries in PAY and every cycle in IDLE.

## Configuration
- Macro OPTICAL_TX_CHECKSUM_EN.
- Defined: the CHK state sends the XOR of all payload bytes (0x00 for an empty payload).
- Undefined: CHK is skipped (PAY → GAP), the checksum register is removed, and frames are 8 bits shorter.

## Structure
- Shared package optical_link_pkg holds:
  - state enum tx_state_t
  - default constants BIT_CYCLES_125K = 216 and PREAMBLE_BYTE = 8'hD5, which the receiver side also uses
  - header bit positions
- One sub-module, bit_tick_gen: a parameterized counter emitting a one-cycle tick every BIT_CYCLES clocks, with a synchronous clear. It replaces standalone clock dividers.

## Test plan
- Single packet {0x12, 0x34 last} on req 0 → tx_bit sequence D5, 00, 12, 34, 26 MSB-first, each bit 216 clocks, then 16 low bits; req_ready[0] pulses twice, 1728 clocks apart.
- Both valid continuously with 1-byte packets → grant alternates 0, 1, 0, 1; header bytes alternate 0x00/0x80.
- Req 1 valid drops after the 2nd of 5 bytes → underrun pulses once and the frame ends with checksum = XOR of 2 bytes.
- 70-byte packet, MAX_LEN = 64 → first frame carries 64 bytes with no underrun; second frame carries 6 bytes.
- Reset asserted mid-payload → tx_bit 0 and busy 0 the next cycle, no req_ready; a fresh request restarts from PREAMBLE.
- OPTICAL_TX_CHECKSUM_EN undefined, same stimulus as the first scenario → D5, 00, 12, 34, then gap; busy spans 32×216 + 16×216 clocks.
